// File: rtl/shift_sequencer.sv
// Multi-cycle operand-2 shifter for the execute stage. It applies the shift at
// up to STEP bit positions per clock and holds busy until the result is ready.
module shift_sequencer #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        imm,
    input  logic        MEM_write_or_read_en,
    input  logic [11:0] shift_operand,
    input  logic [31:0] rm,
    output logic [31:0] val_2,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SH_LSL = 2'd0,
        SH_LSR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROR = 2'd3
    } shift_t;

    localparam logic [5:0] STEP_W = 6'(STEP);

    state_t      state_r, state_next_s;
    shift_t      type_r, type_next_s;
    logic [31:0] acc_r, acc_next_s, stepped_s;
    logic [4:0]  cnt_r, cnt_next_s, k_s;
    logic        busy_r, done_r;

    // Step size for this cycle: never more than the distance still to go.
    always_comb begin
        if ({1'b0, cnt_r} < STEP_W) begin
            k_s = cnt_r;
        end else begin
            k_s = STEP_W[4:0];
        end
    end

    // One narrow shift step; a zero step leaves the accumulator untouched for every type.
    always_comb begin
        case (type_r)
            SH_LSL:  stepped_s = acc_r << k_s;
            SH_LSR:  stepped_s = acc_r >> k_s;
            SH_ASR:  stepped_s = $unsigned($signed(acc_r) >>> k_s);
            SH_ROR:  stepped_s = (acc_r >> k_s) | (acc_r << (6'd32 - {1'b0, k_s}));
            default: stepped_s = acc_r;
        endcase
    end

    // Next-state and datapath update: capture in IDLE, step in SHIFT.
    always_comb begin
        state_next_s = state_r;
        acc_next_s   = acc_r;
        cnt_next_s   = cnt_r;
        type_next_s  = type_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (MEM_write_or_read_en) begin
                        acc_next_s  = {20'd0, shift_operand};
                        cnt_next_s  = 5'd0;
                        type_next_s = SH_LSL;
                    end else if (imm) begin
                        acc_next_s  = {24'd0, shift_operand[7:0]};
                        cnt_next_s  = {shift_operand[11:8], 1'b0};
                        type_next_s = SH_ROR;
                    end else begin
                        acc_next_s  = rm;
                        cnt_next_s  = shift_operand[11:7];
                        type_next_s = shift_t'(shift_operand[6:5]);
                    end
                    state_next_s = (cnt_next_s != 5'd0) ? ST_SHIFT : ST_DONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                acc_next_s = stepped_s;
                cnt_next_s = cnt_r - k_s;
                if (cnt_next_s == 5'd0) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath and status registers; busy/done are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r  <= 32'd0;
            cnt_r  <= 5'd0;
            type_r <= SH_LSL;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            acc_r  <= acc_next_s;
            cnt_r  <= cnt_next_s;
            type_r <= type_next_s;
            busy_r <= (state_next_s != ST_IDLE);
            done_r <= (state_next_s == ST_DONE);
        end
    end

    assign val_2 = acc_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: three instances (STEP 1, 4, 8) share the
// stimulus; each is checked for value, done timing, busy profile and hold.
module tb_shift_sequencer;
    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             imm;
    logic             mem_en;
    logic [11:0]      shift_operand;
    logic [31:0]      rm;
    logic [2:0][31:0] val_v;
    logic [2:0]       busy_v;
    logic [2:0]       done_v;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        mem;
        logic        imm;
        logic [11:0] so;
        logic [31:0] rm;
        logic [31:0] val;
        int          n;
    } vec_t;

    vec_t vecs[11];

    shift_sequencer #(.STEP(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start), .imm(imm),
        .MEM_write_or_read_en(mem_en), .shift_operand(shift_operand), .rm(rm),
        .val_2(val_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );
    shift_sequencer #(.STEP(4)) u_s4 (
        .clk(clk), .rst(rst), .start(start), .imm(imm),
        .MEM_write_or_read_en(mem_en), .shift_operand(shift_operand), .rm(rm),
        .val_2(val_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );
    shift_sequencer #(.STEP(8)) u_s8 (
        .clk(clk), .rst(rst), .start(start), .imm(imm),
        .MEM_write_or_read_en(mem_en), .shift_operand(shift_operand), .rm(rm),
        .val_2(val_v[2]), .busy(busy_v[2]), .done(done_v[2])
    );

    always #5 clk = ~clk;

    function automatic int step_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 4 : 8);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Caller sits 1 time unit after a rising edge (cycle 0); 40-cycle window.
    task automatic run_txn(input vec_t v);
        int          ed[3];
        int          dc[3];
        int          dn[3];
        int          bb[3];
        logic [31:0] vd[3];
        for (int d = 0; d < 3; d++) begin
            ed[d] = (v.n + step_of(d) - 1) / step_of(d) + 1;
            dc[d] = 0;
            dn[d] = 0;
            bb[d] = 0;
            vd[d] = 32'd0;
        end
        start = 1'b1; mem_en = v.mem; imm = v.imm; shift_operand = v.so; rm = v.rm;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                start = 1'b0; mem_en = 1'b0; imm = ~v.imm;
                shift_operand = ~v.so; rm = ~v.rm;
            end
            for (int d = 0; d < 3; d++) begin
                if (done_v[d]) begin
                    dn[d]++;
                    if (dn[d] == 1) begin
                        dc[d] = c;
                        vd[d] = val_v[d];
                    end
                end
                if (busy_v[d] !== (c <= ed[d])) bb[d]++;
            end
        end
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s/S%0d done_cycle", v.name, step_of(d)), 32'(dc[d]), 32'(ed[d]));
            check($sformatf("%s/S%0d done_count", v.name, step_of(d)), 32'(dn[d]), 32'd1);
            check($sformatf("%s/S%0d value", v.name, step_of(d)), vd[d], v.val);
            check($sformatf("%s/S%0d busy_mismatch_cycles", v.name, step_of(d)), 32'(bb[d]), 32'd0);
            check($sformatf("%s/S%0d value_hold", v.name, step_of(d)), val_v[d], v.val);
        end
    endtask

    initial begin
        int          dn;
        int          dc1;
        int          dc2;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] v6;

        vecs[0]  = '{"lsl4",      1'b0, 1'b0, 12'h200, 32'h000000FF, 32'h00000FF0, 4};
        vecs[1]  = '{"imm_rot8",  1'b0, 1'b1, 12'h4FF, 32'hDEADBEEF, 32'hFF000000, 8};
        vecs[2]  = '{"asr31",     1'b0, 1'b0, 12'hFC0, 32'h80000000, 32'hFFFFFFFF, 31};
        vecs[3]  = '{"ror1",      1'b0, 1'b0, 12'h0E0, 32'h00000001, 32'h80000000, 1};
        vecs[4]  = '{"mem_prio",  1'b1, 1'b1, 12'hABC, 32'h55555555, 32'h00000ABC, 0};
        vecs[5]  = '{"lsr7",      1'b0, 1'b0, 12'h3A0, 32'hF0000000, 32'h01E00000, 7};
        vecs[6]  = '{"ror0",      1'b0, 1'b0, 12'h060, 32'h12345678, 32'h12345678, 0};
        vecs[7]  = '{"asr5_pos",  1'b0, 1'b0, 12'h2C0, 32'h40000000, 32'h02000000, 5};
        vecs[8]  = '{"ror12",     1'b0, 1'b0, 12'h660, 32'h12345678, 32'h67812345, 12};
        vecs[9]  = '{"imm_rot30", 1'b0, 1'b1, 12'hF81, 32'h00000000, 32'h00000204, 30};
        vecs[10] = '{"lsl31",     1'b0, 1'b0, 12'hF80, 32'h00000003, 32'h80000000, 31};

        rst = 1'b1; start = 1'b0; imm = 1'b0; mem_en = 1'b0;
        shift_operand = 12'd0; rm = 32'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset/S%0d val_2", step_of(d)), val_v[d], 32'd0);
            check($sformatf("reset/S%0d busy", step_of(d)), 32'(busy_v[d]), 32'd0);
            check($sformatf("reset/S%0d done", step_of(d)), 32'(done_v[d]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i]);
        end

        // Starts while busy are dropped; a start right after done is taken.
        dn = 0; dc1 = 0; dc2 = 0; v1 = 32'd0; v2 = 32'd0; v6 = 32'd0;
        start = 1'b1; mem_en = 1'b0; imm = 1'b0; shift_operand = 12'h200; rm = 32'h000000FF;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 2 || c == 3) begin
                start = 1'b1; mem_en = 1'b1; shift_operand = 12'hABC; rm = 32'h11111111;
            end else if (c == 6) begin
                start = 1'b1; mem_en = 1'b1; shift_operand = 12'h123; rm = 32'h22222222;
            end else begin
                start = 1'b0; mem_en = 1'b0;
            end
            if (c == 6) v6 = val_v[0];
            if (done_v[0]) begin
                dn++;
                if (dn == 1) begin dc1 = c; v1 = val_v[0]; end
                if (dn == 2) begin dc2 = c; v2 = val_v[0]; end
            end
        end
        check("busy_ignore done_count", 32'(dn), 32'd2);
        check("busy_ignore first_done_cycle", 32'(dc1), 32'd5);
        check("busy_ignore first_value", v1, 32'h00000FF0);
        check("busy_ignore hold_after_done", v6, 32'h00000FF0);
        check("after_done second_done_cycle", 32'(dc2), 32'd7);
        check("after_done second_value", v2, 32'h00000123);
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        // Reset during a 31-position shift discards it.
        dn = 0;
        start = 1'b1; mem_en = 1'b0; imm = 1'b0; shift_operand = 12'hF80; rm = 32'h00000003;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 4) begin
                for (int d = 0; d < 3; d++) begin
                    check($sformatf("mid_reset/S%0d val_2", step_of(d)), val_v[d], 32'd0);
                    check($sformatf("mid_reset/S%0d busy", step_of(d)), 32'(busy_v[d]), 32'd0);
                    check($sformatf("mid_reset/S%0d done", step_of(d)), 32'(done_v[d]), 32'd0);
                end
            end
            rst = (c == 3) ? 1'b1 : 1'b0;
            if (|done_v) dn++;
        end
        check("mid_reset no_done", 32'(dn), 32'd0);
        run_txn(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle sequencer for the operand-2 shifter of the ARM execute stage. It accepts one shift request per transaction, captures the operand, and applies the shift or rotate at up to STEP bit positions per clock, so one narrow shift step can replace the full 32-bit barrel shifter. It produces the same value the single-cycle val2 path would produce, and raises `busy` so the hazard unit can freeze the pipeline until `done`.

## Interface
- STEP, 1: bit positions shifted per SHIFT cycle. Legal values are 1, 2, 4, 8, 16, 32.
- clk  in  1  rising-edge clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe. Sampled only in IDLE.
- imm  in  1  immediate operand form (8-bit value rotated right by 2×rot).
- MEM_write_or_read_en  in  1  load/store form (zero-extended 12-bit offset, no shift). Takes priority over `imm`.
- shift_operand  in  12  instruction operand field.
- rm  in  32  register operand.
- val_2  out  32  result. Holds its value from `done` until the next accepted `start`.
- busy  out  1  high in SHIFT and DONE. Feeds the pipeline stall.
- done  out  1  one-cycle pulse marking `val_2` valid.

## Operation
- States:
  - IDLE: accepts a request.
  - SHIFT: performs one step per cycle.
  - DONE: asserts `done` for exactly 1 cycle, then returns to IDLE.
- Capture on an accepted start (IDLE & start), in priority order:
  - If MEM_write_or_read_en: acc = {20'b0, shift_operand}, cnt = 0.
  - Else if imm: acc = {24'b0, shift_operand[7:0]}, type = ROR, cnt = {shift_operand[11:8], 1'b0} (range 0..30).
  - Else: acc = rm, type = shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR), cnt = shift_operand[11:7] (range 0..31).
- Next state after capture: SHIFT if cnt ≠ 0, otherwise DONE.
- Each SHIFT cycle:
  - k = min(STEP, cnt).
  - acc is updated by k positions according to type: LSL zero-fill, LSR zero-fill, ASR sign-fill from acc[31], ROR bit rotation.
  - cnt is decremented by k.
  - When the new cnt is 0, go to DONE.
- A shift amount of 0 returns the captured value unchanged for every type. There is no RRX or ARM "LSR #0 = 32" special case.
- `val_2` is driven from acc.
- `start` is ignored in SHIFT and DONE; no request is queued. Operand inputs are don't-care except in the capture cycle.
- Reset, including in the middle of a transaction: state = IDLE, acc = 0, cnt = 0, val_2 = 0, busy = 0, done = 0. Any transaction in flight is discarded.
- The 5-bit cnt never underflows, because k ≤ cnt.

## Timing
- Let start be accepted in cycle 0 and n = captured cnt.
- `done` is high in cycle ceil(n/STEP)+1. With n = 0, that is cycle 1.
- `busy` rises in cycle 1 and falls in the cycle after `done`.
- Earliest next accept: cycle ceil(n/STEP)+2.
- Worst case with STEP=1: n = 31, `done` in cycle 32.
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.

## Test plan
- LSL, STEP=1: rm = 0x000000FF, shift_operand = 0x200 (amount 4, LSL) → `done` in cycle 5, val_2 = 0x00000FF0, `busy` high in cycles 1–5.
- Immediate, STEP=1: imm = 1, shift_operand = 0x4FF (rot 4, rotate by 8) → val_2 = 0xFF000000, `done` in cycle 9. With STEP=8: `done` in cycle 2, same value.
- ASR/ROR, STEP=4:
  - rm = 0x80000000, amount 31, ASR → val_2 = 0xFFFFFFFF, `done` in cycle 9.
  - rm = 0x00000001, amount 1, ROR → val_2 = 0x80000000, `done` in cycle 2.
- Memory priority: MEM_write_or_read_en = 1, imm = 1, shift_operand = 0xABC → val_2 = 0x00000ABC, `done` in cycle 1 with no SHIFT cycles.
- Busy-ignore: issue a second start with different operands in cycles 2 and 3 of an LSL-by-4 transaction (STEP=1) → the first result is unchanged and no second `done` occurs. A start in the cycle after `done` is accepted.
- Reset mid-shift: assert rst in cycle 3 of a 31-bit shift → next cycle state = IDLE, val_2 = 0, busy = 0, no `done`. A new request completes normally afterward.
